// File: rtl/free_list_multi_pkg.sv
`default_nettype none
// ============================================================================
// free_list_multi_pkg : shared sizing constants and tag/pointer types
// Rev 1.0
// ============================================================================
package free_list_multi_pkg;

  localparam int NUM_PHYS_REGS = 64;
  localparam int NUM_ARCH_REGS = 32;
  localparam int LP            = $clog2(NUM_PHYS_REGS);

  typedef logic [LP-1:0] phys_tag_t;
  typedef logic [LP:0]   ptr_t;

endpackage
`default_nettype wire

// File: rtl/free_list_multi_lane_compactor.sv
`default_nettype none
// ============================================================================
// lane_compactor : squeezes valid free lanes to the low end, ascending order
// Rev 1.0
// ============================================================================
module lane_compactor
  import free_list_multi_pkg::*;
#(
  parameter int ENQ_WIDTH = 2,
  parameter int TAG_W     = LP
) (
  input  logic [ENQ_WIDTH-1:0]           valid_i,
  input  logic [ENQ_WIDTH*TAG_W-1:0]     data_i,
  output logic [ENQ_WIDTH*TAG_W-1:0]     packed_o,
  output logic [$clog2(ENQ_WIDTH+1)-1:0] count_o
);

  localparam int c_cw = $clog2(ENQ_WIDTH+1);

  int w_idx;

  always_comb begin
    packed_o = '0;
    w_idx    = 0;
    for (int l = 0; l < ENQ_WIDTH; l++) begin
      if (valid_i[l]) begin
        packed_o[w_idx*TAG_W +: TAG_W] = data_i[l*TAG_W +: TAG_W];
        w_idx = w_idx + 1;
      end
    end
    count_o = c_cw'(w_idx);
  end

endmodule
`default_nettype wire

// File: rtl/free_list_multi.sv
`default_nettype none
// ============================================================================
// free_list_multi : multi-port circular free list of physical register tags
// Rev 1.0
// ============================================================================
module free_list_multi #(
  parameter int NUM_PHYS_REGS = free_list_multi_pkg::NUM_PHYS_REGS,
  parameter int NUM_ARCH_REGS = free_list_multi_pkg::NUM_ARCH_REGS,
  parameter int DEQ_WIDTH     = 2,
  parameter int ENQ_WIDTH     = 2
) (
  input  logic                                        CLK,
  input  logic                                        RESET,
  input  logic [$clog2(DEQ_WIDTH+1)-1:0]              DeqCount_IN,
  output logic                                        DeqGrant_OUT,
  output logic [DEQ_WIDTH*$clog2(NUM_PHYS_REGS)-1:0]  DeqData_OUT,
  input  logic [ENQ_WIDTH-1:0]                        EnqValid_IN,
  input  logic [ENQ_WIDTH*$clog2(NUM_PHYS_REGS)-1:0]  EnqData_IN,
  output logic                                        Overflow_OUT,
  output logic [$clog2(NUM_PHYS_REGS):0]              FreeCount_OUT,
  output logic [$clog2(NUM_PHYS_REGS):0]              HeadSnap_OUT,
  input  logic                                        Restore_IN,
  input  logic [$clog2(NUM_PHYS_REGS):0]              RestoreHead_IN
);

  localparam int c_lp  = $clog2(NUM_PHYS_REGS);
  localparam int c_ecw = $clog2(ENQ_WIDTH+1);

  logic [c_lp:0]   head_q, head_d;
  logic [c_lp:0]   tail_q, tail_d;
  logic [c_lp-1:0] mem_q [NUM_PHYS_REGS];

  logic [c_lp:0]                 w_count;
  logic                          w_grant;
  logic [c_lp:0]                 w_deq_amt;
  logic [c_lp+1:0]               w_occupancy;
  logic                          w_overflow;
  logic [ENQ_WIDTH*c_lp-1:0]     w_enq_packed;
  logic [c_ecw-1:0]              w_enq_cnt;

  lane_compactor #(
    .ENQ_WIDTH (ENQ_WIDTH),
    .TAG_W     (c_lp)
  ) u_lane_compactor (
    .valid_i  (EnqValid_IN),
    .data_i   (EnqData_IN),
    .packed_o (w_enq_packed),
    .count_o  (w_enq_cnt)
  );

  // Grant uses the pre-edge count so same-cycle frees are never handed out.
  always_comb begin
    w_count     = tail_q - head_q;
    w_grant     = (DeqCount_IN != '0) && (int'(DeqCount_IN) <= DEQ_WIDTH) &&
                  ((c_lp+1)'(DeqCount_IN) <= w_count) && !Restore_IN;
    w_deq_amt   = w_grant ? (c_lp+1)'(DeqCount_IN) : '0;
    w_occupancy = {1'b0, w_count} + (c_lp+2)'(w_enq_cnt) - (c_lp+2)'(w_deq_amt);
    w_overflow  = w_occupancy > (c_lp+2)'(NUM_PHYS_REGS);
    head_d      = Restore_IN ? RestoreHead_IN : head_q + w_deq_amt;
    tail_d      = w_overflow ? tail_q : tail_q + (c_lp+1)'(w_enq_cnt);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      head_q <= '0;
      tail_q <= (c_lp+1)'(NUM_PHYS_REGS - NUM_ARCH_REGS);
      for (int i = 0; i < NUM_PHYS_REGS; i++) begin
        mem_q[i] <= (i < NUM_PHYS_REGS - NUM_ARCH_REGS) ? c_lp'(NUM_ARCH_REGS + i) : '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (!w_overflow) begin
        for (int j = 0; j < ENQ_WIDTH; j++) begin
          if (j < int'(w_enq_cnt)) begin
            mem_q[tail_q[c_lp-1:0] + c_lp'(j)] <= w_enq_packed[j*c_lp +: c_lp];
          end
        end
      end
    end
  end

  generate
    for (genvar k = 0; k < DEQ_WIDTH; k++) begin : g_deq_lane
      assign DeqData_OUT[k*c_lp +: c_lp] = mem_q[head_q[c_lp-1:0] + c_lp'(k)];
    end
  endgenerate

  assign DeqGrant_OUT  = w_grant;
  assign Overflow_OUT  = w_overflow;
  assign FreeCount_OUT = w_count;
  assign HeadSnap_OUT  = head_q;

endmodule
`default_nettype wire

// File: tb/tb_free_list_multi.sv
`default_nettype none
// ============================================================================
// tb_free_list_multi : directed scenario bench for free_list_multi
// Rev 1.0
// ============================================================================
module tb_free_list_multi;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [1:0]  DeqCount_IN = '0;
  logic        DeqGrant_OUT;
  logic [11:0] DeqData_OUT;
  logic [1:0]  EnqValid_IN = '0;
  logic [11:0] EnqData_IN = '0;
  logic        Overflow_OUT;
  logic [6:0]  FreeCount_OUT;
  logic [6:0]  HeadSnap_OUT;
  logic        Restore_IN = 1'b0;
  logic [6:0]  RestoreHead_IN = '0;

  int errors = 0;
  int checks = 0;

  free_list_multi #(
    .NUM_PHYS_REGS (64),
    .NUM_ARCH_REGS (32),
    .DEQ_WIDTH     (2),
    .ENQ_WIDTH     (2)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .DeqCount_IN    (DeqCount_IN),
    .DeqGrant_OUT   (DeqGrant_OUT),
    .DeqData_OUT    (DeqData_OUT),
    .EnqValid_IN    (EnqValid_IN),
    .EnqData_IN     (EnqData_IN),
    .Overflow_OUT   (Overflow_OUT),
    .FreeCount_OUT  (FreeCount_OUT),
    .HeadSnap_OUT   (HeadSnap_OUT),
    .Restore_IN     (Restore_IN),
    .RestoreHead_IN (RestoreHead_IN)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    DeqCount_IN    = '0;
    EnqValid_IN    = '0;
    EnqData_IN     = '0;
    Restore_IN     = 1'b0;
    RestoreHead_IN = '0;
  endtask

  task automatic do_reset();
    idle();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (FreeCount_OUT !== 7'd32) begin errors++; $display("FAIL reset_count: got %0d want 32", FreeCount_OUT); end
    checks++; if (DeqData_OUT[5:0] !== 6'd32) begin errors++; $display("FAIL reset_lane0: got %0d want 32", DeqData_OUT[5:0]); end
    checks++; if (DeqData_OUT[11:6] !== 6'd33) begin errors++; $display("FAIL reset_lane1: got %0d want 33", DeqData_OUT[11:6]); end
    checks++; if (HeadSnap_OUT !== 7'd0) begin errors++; $display("FAIL reset_head: got %0d want 0", HeadSnap_OUT); end
    checks++; if (DeqGrant_OUT !== 1'b0) begin errors++; $display("FAIL reset_grant: got %0b want 0", DeqGrant_OUT); end
    checks++; if (Overflow_OUT !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", Overflow_OUT); end
    DeqCount_IN = 2'd3;
    #1;
    checks++; if (DeqGrant_OUT !== 1'b0) begin errors++; $display("FAIL deq_over_width: got %0b want 0", DeqGrant_OUT); end
    DeqCount_IN = 2'd2;
    #1;
    checks++; if (DeqGrant_OUT !== 1'b1) begin errors++; $display("FAIL deq_two_grant: got %0b want 1", DeqGrant_OUT); end
    idle();
  endtask

  task automatic test_drain();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      DeqCount_IN = 2'd2;
      #1;
      checks++; if (DeqGrant_OUT !== 1'b1) begin errors++; $display("FAIL drain_grant[%0d]: got %0b want 1", i, DeqGrant_OUT); end
      checks++; if (DeqData_OUT[5:0] !== 6'(32 + 2*i)) begin errors++; $display("FAIL drain_lane0[%0d]: got %0d want %0d", i, DeqData_OUT[5:0], 32 + 2*i); end
      checks++; if (DeqData_OUT[11:6] !== 6'(33 + 2*i)) begin errors++; $display("FAIL drain_lane1[%0d]: got %0d want %0d", i, DeqData_OUT[11:6], 33 + 2*i); end
      tick();
    end
    DeqCount_IN = 2'd2;
    #1;
    checks++; if (DeqGrant_OUT !== 1'b0) begin errors++; $display("FAIL empty_grant: got %0b want 0", DeqGrant_OUT); end
    checks++; if (FreeCount_OUT !== 7'd0) begin errors++; $display("FAIL empty_count: got %0d want 0", FreeCount_OUT); end
    idle();
  endtask

  task automatic test_enq_same_cycle();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      DeqCount_IN = 2'd2;
      tick();
    end
    DeqCount_IN = 2'd1;
    tick();
    checks++; if (FreeCount_OUT !== 7'd1) begin errors++; $display("FAIL one_left_count: got %0d want 1", FreeCount_OUT); end
    DeqCount_IN = 2'd2;
    EnqValid_IN = 2'b01;
    EnqData_IN  = {6'd0, 6'd5};
    #1;
    checks++; if (DeqGrant_OUT !== 1'b0) begin errors++; $display("FAIL same_cycle_grant: got %0b want 0", DeqGrant_OUT); end
    checks++; if (Overflow_OUT !== 1'b0) begin errors++; $display("FAIL same_cycle_ovf: got %0b want 0", Overflow_OUT); end
    tick();
    idle();
    #1;
    checks++; if (FreeCount_OUT !== 7'd2) begin errors++; $display("FAIL after_enq_count: got %0d want 2", FreeCount_OUT); end
    checks++; if (DeqData_OUT[5:0] !== 6'd63) begin errors++; $display("FAIL after_enq_lane0: got %0d want 63", DeqData_OUT[5:0]); end
    checks++; if (DeqData_OUT[11:6] !== 6'd5) begin errors++; $display("FAIL after_enq_lane1: got %0d want 5", DeqData_OUT[11:6]); end
  endtask

  task automatic test_restore();
    logic [6:0] snap;
    do_reset();
    snap = HeadSnap_OUT;
    checks++; if (snap !== 7'd0) begin errors++; $display("FAIL snap_head: got %0d want 0", snap); end
    for (int i = 0; i < 3; i++) begin
      DeqCount_IN = 2'd2;
      tick();
    end
    idle();
    #1;
    checks++; if (FreeCount_OUT !== 7'd26) begin errors++; $display("FAIL pre_restore_count: got %0d want 26", FreeCount_OUT); end
    checks++; if (HeadSnap_OUT !== 7'd6) begin errors++; $display("FAIL pre_restore_head: got %0d want 6", HeadSnap_OUT); end
    Restore_IN     = 1'b1;
    RestoreHead_IN = snap;
    DeqCount_IN    = 2'd2;
    #1;
    checks++; if (DeqGrant_OUT !== 1'b0) begin errors++; $display("FAIL restore_grant: got %0b want 0", DeqGrant_OUT); end
    tick();
    idle();
    #1;
    checks++; if (FreeCount_OUT !== 7'd32) begin errors++; $display("FAIL restore_count: got %0d want 32", FreeCount_OUT); end
    checks++; if (DeqData_OUT[5:0] !== 6'd32) begin errors++; $display("FAIL restore_lane0: got %0d want 32", DeqData_OUT[5:0]); end
    checks++; if (HeadSnap_OUT !== 7'd0) begin errors++; $display("FAIL restore_head: got %0d want 0", HeadSnap_OUT); end
  endtask

  task automatic test_overflow();
    logic [5:0] exp_tag;
    do_reset();
    // Slots 32..62 receive tags 0..30.
    for (int m = 0; m < 15; m++) begin
      EnqValid_IN = 2'b11;
      EnqData_IN  = {6'(2*m + 1), 6'(2*m)};
      tick();
    end
    EnqValid_IN = 2'b01;
    EnqData_IN  = {6'd0, 6'd30};
    tick();
    idle();
    #1;
    checks++; if (FreeCount_OUT !== 7'd63) begin errors++; $display("FAIL fill_count: got %0d want 63", FreeCount_OUT); end
    EnqValid_IN = 2'b11;
    EnqData_IN  = {6'd41, 6'd40};
    #1;
    checks++; if (Overflow_OUT !== 1'b1) begin errors++; $display("FAIL overflow_flag: got %0b want 1", Overflow_OUT); end
    tick();
    idle();
    #1;
    checks++; if (FreeCount_OUT !== 7'd63) begin errors++; $display("FAIL overflow_count: got %0d want 63", FreeCount_OUT); end
    checks++; if (Overflow_OUT !== 1'b0) begin errors++; $display("FAIL overflow_clear: got %0b want 0", Overflow_OUT); end
    DeqCount_IN = 2'd2;
    tick();
    DeqCount_IN = 2'd1;
    tick();
    DeqCount_IN = 2'd0;
    EnqValid_IN = 2'b10;
    EnqData_IN  = {6'd7, 6'd9};
    #1;
    checks++; if (FreeCount_OUT !== 7'd60) begin errors++; $display("FAIL sixty_count: got %0d want 60", FreeCount_OUT); end
    checks++; if (Overflow_OUT !== 1'b0) begin errors++; $display("FAIL lane1_ovf: got %0b want 0", Overflow_OUT); end
    tick();
    idle();
    for (int s = 3; s < 63; s += 2) begin
      exp_tag = (s < 32) ? 6'(s + 32) : 6'(s - 32);
      DeqCount_IN = 2'd2;
      #1;
      checks++; if (DeqData_OUT[5:0] !== exp_tag) begin errors++; $display("FAIL walk_lane0[%0d]: got %0d want %0d", s, DeqData_OUT[5:0], exp_tag); end
      tick();
    end
    idle();
    #1;
    checks++; if (FreeCount_OUT !== 7'd1) begin errors++; $display("FAIL old_tail_count: got %0d want 1", FreeCount_OUT); end
    checks++; if (DeqData_OUT[5:0] !== 6'd7) begin errors++; $display("FAIL old_tail_tag: got %0d want 7", DeqData_OUT[5:0]); end
  endtask

  task automatic test_wrap_and_reset();
    logic [5:0] e0, e1;
    do_reset();
    // Recycling each dequeued pair keeps the tag order periodic over 32..63.
    for (int c = 0; c < 70; c++) begin
      e0 = 6'(32 + ((2*c) % 32));
      e1 = 6'(32 + ((2*c + 1) % 32));
      DeqCount_IN = 2'd2;
      EnqValid_IN = 2'b11;
      EnqData_IN  = {e1, e0};
      #1;
      checks++; if (DeqGrant_OUT !== 1'b1) begin errors++; $display("FAIL wrap_grant[%0d]: got %0b want 1", c, DeqGrant_OUT); end
      checks++; if (FreeCount_OUT !== 7'd32) begin errors++; $display("FAIL wrap_count[%0d]: got %0d want 32", c, FreeCount_OUT); end
      checks++; if (DeqData_OUT !== {e1, e0}) begin errors++; $display("FAIL wrap_lanes[%0d]: got %h want %h", c, DeqData_OUT, {e1, e0}); end
      tick();
    end
    idle();
    #1;
    checks++; if (HeadSnap_OUT !== 7'd12) begin errors++; $display("FAIL wrap_head: got %0d want 12", HeadSnap_OUT); end
    checks++; if (FreeCount_OUT !== 7'd32) begin errors++; $display("FAIL wrap_final_count: got %0d want 32", FreeCount_OUT); end
    RESET          = 1'b1;
    DeqCount_IN    = 2'd2;
    EnqValid_IN    = 2'b11;
    EnqData_IN     = {6'd1, 6'd2};
    Restore_IN     = 1'b1;
    RestoreHead_IN = 7'd5;
    tick();
    RESET = 1'b0;
    idle();
    #1;
    checks++; if (FreeCount_OUT !== 7'd32) begin errors++; $display("FAIL mid_reset_count: got %0d want 32", FreeCount_OUT); end
    checks++; if (DeqData_OUT !== {6'd33, 6'd32}) begin errors++; $display("FAIL mid_reset_lanes: got %h want %h", DeqData_OUT, {6'd33, 6'd32}); end
    checks++; if (HeadSnap_OUT !== 7'd0) begin errors++; $display("FAIL mid_reset_head: got %0d want 0", HeadSnap_OUT); end
    checks++; if (Overflow_OUT !== 1'b0) begin errors++; $display("FAIL mid_reset_ovf: got %0b want 0", Overflow_OUT); end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_enq_same_cycle();
    test_restore();
    test_overflow();
    test_wrap_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/free_list_multi.md
FREE_LIST_MULTI -- requirements
Module: free_list_multi

Interface
REQ-001 The block SHALL use parameter NUM_PHYS_REGS, default 64, meaning the total number of physical registers (power of two, at least 4).
REQ-002 The block SHALL use parameter NUM_ARCH_REGS, default 32, meaning the number of registers architecturally mapped at reset (less than NUM_PHYS_REGS).
REQ-003 The block SHALL use parameter DEQ_WIDTH, default 2, meaning the number of allocations per cycle (1..4).
REQ-004 The block SHALL use parameter ENQ_WIDTH, default 2, meaning the number of frees per cycle (1..4).
REQ-005 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-006 The block SHALL have the following ports. LP = clog2(NUM_PHYS_REGS).
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- DeqCount_IN  in  clog2(DEQ_WIDTH+1)  registers requested this cycle
- DeqGrant_OUT  out  1  request satisfied, all-or-nothing
- DeqData_OUT  out  DEQ_WIDTH*LP  lane k = k-th entry from head
- EnqValid_IN  in  ENQ_WIDTH  per-lane free valid
- EnqData_IN  in  ENQ_WIDTH*LP  per-lane freed register tag
- Overflow_OUT  out  1  enqueue rejected this cycle
- FreeCount_OUT  out  LP+1  entries currently free
- HeadSnap_OUT  out  LP+1  current head pointer, including wrap bit, for checkpointing
- Restore_IN  in  1  rewind head to RestoreHead_IN
- RestoreHead_IN  in  LP+1  previously snapshotted head

Function
REQ-007 Storage SHALL be a circular array of NUM_PHYS_REGS entries of LP bits, with head and tail pointers of LP+1 bits (MSB = wrap bit); count SHALL equal tail minus head, modulo 2^(LP+1).
REQ-008 FreeCount_OUT SHALL equal count and DeqData_OUT lane k SHALL equal queue[(head+k) mod NUM_PHYS_REGS], both combinational from registered state.
REQ-009 DeqGrant_OUT SHALL be 1 iff DeqCount_IN is nonzero and DeqCount_IN is at most count (pre-edge value) and Restore_IN is 0; it is combinational.
REQ-010 When a dequeue is granted, head SHALL advance by DeqCount_IN at the next CLK edge; only lanes 0..DeqCount_IN-1 are consumed.
REQ-011 Valid enqueue lanes SHALL be compacted in ascending lane order and written to consecutive slots starting at tail; tail SHALL advance by popcount(EnqValid_IN).
REQ-012 An enqueue SHALL be rejected as a whole if count + popcount(EnqValid_IN) - (granted dequeue count) exceeds NUM_PHYS_REGS; Overflow_OUT SHALL be 1 in that cycle, and tail and storage SHALL be unchanged.
REQ-013 Entries enqueued in a cycle SHALL NOT be dequeueable in the same cycle; the grant check uses the pre-edge count.
REQ-014 When Restore_IN is 1, head SHALL be loaded with RestoreHead_IN at the next edge, and dequeue SHALL be suppressed that cycle; a simultaneous enqueue SHALL still be performed.
REQ-015 Pointer increments SHALL wrap modulo 2^(LP+1), and array indexing SHALL use the low LP bits.
REQ-016 DeqCount_IN values greater than DEQ_WIDTH SHALL be treated as no request (grant 0).

Reset
REQ-017 When RESET is high at a CLK edge, head SHALL be set to 0 and tail to NUM_PHYS_REGS-NUM_ARCH_REGS, and queue[i] SHALL be set to NUM_ARCH_REGS+i for i < NUM_PHYS_REGS-NUM_ARCH_REGS.
REQ-018 After reset, FreeCount_OUT SHALL be NUM_PHYS_REGS-NUM_ARCH_REGS, DeqGrant_OUT SHALL be 0 unless a valid request is present, and Overflow_OUT SHALL be 0.
REQ-019 RESET SHALL override Restore_IN, enqueue and dequeue in the same cycle; operations in flight SHALL be discarded.
REQ-020 There SHALL be no initial-block initialisation; reset is the only initialisation mechanism.

Structure
REQ-021 A shared package SHALL hold NUM_PHYS_REGS, NUM_ARCH_REGS, LP, the physical-tag typedef (LP bits) and the pointer typedef (LP+1 bits).
REQ-022 The block SHALL contain one sub-module, lane_compactor, which maps EnqValid_IN/EnqData_IN to a packed list plus popcount.
REQ-023 The block SHALL contain no other sub-modules.

Verification
REQ-024 Reset, then read state -> FreeCount_OUT=32, DeqData_OUT lanes = {32,33}, HeadSnap_OUT=0.
REQ-025 DeqCount_IN=2 for 16 cycles -> all granted with tags 32..63 in order; cycle 17 gives DeqGrant_OUT=0 and FreeCount_OUT=0.
REQ-026 With count=1, DeqCount_IN=2 and an enqueue of tag 5 in the same cycle -> no grant; next cycle FreeCount_OUT=2 and DeqData_OUT lanes = {remaining tag, 5}.
REQ-027 Snapshot at head=0, dequeue 6, then Restore_IN=1 with RestoreHead_IN=0 -> FreeCount_OUT back to 32, DeqData_OUT lane 0 = 32.
REQ-028 With count=63, enqueue 2 lanes -> Overflow_OUT=1 and count stays 63; EnqValid_IN=2'b10 with tag 7 and count=60 -> tag 7 appears at the old tail.
REQ-029 Tail wraps past 127 (wrap bit toggles) -> count stays correct and RESET mid-sequence restores the REQ-024 state.
